ps2_move_tracker: RTL
=====================

# ps2_move_tracker

Converts the raw PS/2 byte stream from `PS2_Controller` into held-key state and paced movement commands for the block-drawing stage. It decodes make, break (`F0`) and extended (`E0`) scancode sequences for W/A/S/D and the arrow keys, and tracks which keys are held. It issues one move immediately on a new press, then repeats the move at a programmable rate while the key stays held. It sits between `PS2_Controller` and the block mover, and replaces ad-hoc scancode latching in the top level.

## Interface
- `REPEAT_DELAY`, default 25_000_000: cycles from the initial move to the first auto-repeat.
- `REPEAT_RATE`, default 5_000_000: cycles between subsequent auto-repeats.
- `CLOCK_50`  in  1  sole clock; all logic is on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `ps2_data`  in  8  received byte; valid only when `ps2_data_en`=1.
- `ps2_data_en`  in  1  one-cycle strobe per received byte.
- `move_ready`  in  1  consumer accepts the pending move.
- `move_valid`  out  1  move pending.
- `move_dir`  out  2  00 up, 01 left, 10 down, 11 right.
- `keys_held`  out  4  bit order {up, left, down, right}.
- `last_code`  out  8  last non-prefix byte received, for HEX display.

## Operation
- Key map:
  - Up: `1D` (W) or `E0 75`.
  - Left: `1C` (A) or `E0 6B`.
  - Down: `1B` (S) or `E0 72`.
  - Right: `23` (D) or `E0 74`.
  - All other codes are unmapped.
- Parser FSM has four states: IDLE, BRK, EXT, EXT_BRK. Transitions are taken only on `ps2_data_en`.
  - IDLE:
    - `F0` → BRK.
    - `E0` → EXT.
    - Any other byte is a make code; stay in IDLE.
  - BRK: the byte is a break code. A mapped non-extended code clears its held bit. → IDLE.
  - EXT:
    - `F0` → EXT_BRK.
    - A mapped arrow is a make code → IDLE.
    - Anything else → IDLE, ignored.
  - EXT_BRK: a mapped arrow clears its bit. → IDLE.
- Every non-prefix byte updates `last_code`; `F0` and `E0` do not.
- A make code for a key that is not currently held:
  - Sets its held bit.
  - Makes it the active direction.
  - Requests an immediate move.
  - Loads the repeat counter with `REPEAT_DELAY`.
- A make code for a key already held (keyboard typematic) is ignored for movement.
- Auto-repeat:
  - While the active key is held, the counter decrements once per cycle.
  - At 0 it requests a move and reloads with `REPEAT_RATE`.
- Releasing the active key:
  - If other keys remain held, the new active key is chosen by fixed priority up > left > down > right. The counter reloads with `REPEAT_DELAY`. No immediate move is issued.
  - If no keys remain held, the counter stops and no further moves are issued.
- Releasing a non-active key changes only `keys_held`.
- Handshake:
  - `move_valid` stays high until a cycle with `move_ready`=1.
  - `move_dir` is stable while valid, with one exception: a new-press request while a move is pending overwrites `move_dir`, because the latest intent wins.
  - A repeat request while a move is pending is dropped.
  - If a move request and acceptance occur in the same cycle, `move_valid` stays high carrying the new direction.
- The counter is `$clog2(max(REPEAT_DELAY, REPEAT_RATE)+1)` bits and never underflows.

## Timing
- Reset values: `move_valid`=0, `move_dir`=00, `keys_held`=0000, `last_code`=00. FSM is in IDLE, counter is 0, no key is active.
- Reset asserted mid-sequence (for example after `F0`): all state is cleared at the next edge, and the following byte is parsed from IDLE.
- `keys_held` and `last_code` update on the edge after the strobe (1-cycle latency).
- An immediate move asserts `move_valid` on the edge after the make-code strobe.
- The first repeat asserts `REPEAT_DELAY`+1 cycles after the initial `move_valid` rise.
- Later repeats occur every `REPEAT_RATE` cycles, measured independently of when each move is accepted.
- Bytes arriving back-to-back on consecutive cycles are all processed; no strobe is lost.

## Test plan
- Use `REPEAT_DELAY`=10 and `REPEAT_RATE`=4 for all scenarios.
- Strobe `1D` with `move_ready`=1. Required: `keys_held`=1000, a single-cycle `move_valid` with `move_dir`=00, `last_code`=1D. Hold for 25 cycles. Required: repeats at +11, +15, +19 and +23 cycles after the first move.
- Strobe `1C`, then `F0 1C`. Required: `keys_held` returns to 0000 and no repeat occurs after the release. With the sequence `F0` alone followed by a reset, the next `1C` is treated as a make code.
- Strobe `E0 74` then `E0 F0 74`. Required: right is set, then cleared; `move_dir`=11; `last_code`=74.
- Hold `1B`, then press `23`. Required: an immediate move with `move_dir`=11. Then release `23`. Required: active direction becomes down, no immediate move, next move after 11 cycles with `move_dir`=10.
- Hold `move_ready`=0 and press `1D` then `1C`. Required: `move_valid` stays high, `move_dir` changes from 00 to 01, and the repeat tick that falls due while pending is dropped. Raising `move_ready` for one cycle clears `move_valid`.
- Repeated `1D` make strobes while up is already held. Required: no extra moves; repeat spacing is unchanged.

Source files
------------

// File: rtl/ps2_move_tracker.sv
// PS/2 scancode decoder for W/A/S/D and the arrow keys. It tracks which keys are held
// and issues paced move commands: one immediate move per new press, then auto-repeat.
module ps2_move_tracker #(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_data_en,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] keys_held,
    output logic [7:0] last_code
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY);
    // The tick at zero uses up one cycle, so reloading with RATE-1 spaces repeats RATE apart.
    localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          active_valid;
    logic [1:0]    active_dir;

    logic [2:0] plain_map, ext_map;
    logic       make_hit, brk_hit, is_prefix;
    logic [1:0] key_dir;
    logic [3:0] key_mask, held_after_brk;
    logic       new_press, brk_active, repeat_req;

    // Each lookup returns {hit, dir}.
    function automatic logic [2:0] map_plain(input logic [7:0] b);
        case (b)
            8'h1D:   map_plain = 3'b1_00;
            8'h1C:   map_plain = 3'b1_01;
            8'h1B:   map_plain = 3'b1_10;
            8'h23:   map_plain = 3'b1_11;
            default: map_plain = 3'b0_00;
        endcase
    endfunction

    function automatic logic [2:0] map_ext(input logic [7:0] b);
        case (b)
            8'h75:   map_ext = 3'b1_00;
            8'h6B:   map_ext = 3'b1_01;
            8'h72:   map_ext = 3'b1_10;
            8'h74:   map_ext = 3'b1_11;
            default: map_ext = 3'b0_00;
        endcase
    endfunction

    function automatic logic [1:0] prio_dir(input logic [3:0] held);
        if (held[3])      prio_dir = 2'b00;
        else if (held[2]) prio_dir = 2'b01;
        else if (held[1]) prio_dir = 2'b10;
        else              prio_dir = 2'b11;
    endfunction

    assign plain_map = map_plain(ps2_data);
    assign ext_map   = map_ext(ps2_data);
    assign is_prefix = (ps2_data == 8'hF0) || (ps2_data == 8'hE0);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        make_hit   = 1'b0;
        brk_hit    = 1'b0;
        key_dir    = 2'b00;
        if (ps2_data_en) begin
            case (state)
                S_IDLE: begin
                    if (ps2_data == 8'hF0)      state_next = S_BRK;
                    else if (ps2_data == 8'hE0) state_next = S_EXT;
                    else begin
                        make_hit = plain_map[2];
                        key_dir  = plain_map[1:0];
                    end
                end
                S_BRK: begin
                    brk_hit    = plain_map[2];
                    key_dir    = plain_map[1:0];
                    state_next = S_IDLE;
                end
                S_EXT: begin
                    if (ps2_data == 8'hF0) state_next = S_EXT_BRK;
                    else begin
                        make_hit   = ext_map[2];
                        key_dir    = ext_map[1:0];
                        state_next = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    brk_hit    = ext_map[2];
                    key_dir    = ext_map[1:0];
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign key_mask       = 4'b1000 >> key_dir;
    assign held_after_brk = keys_held & ~key_mask;
    assign new_press      = make_hit && ((keys_held & key_mask) == 4'b0000);
    assign brk_active     = brk_hit && active_valid && (key_dir == active_dir);
    assign repeat_req     = active_valid && (cnt == '0) && !new_press && !brk_active;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            keys_held    <= 4'b0000;
            last_code    <= 8'h00;
            cnt          <= '0;
            active_valid <= 1'b0;
            active_dir   <= 2'b00;
            move_valid   <= 1'b0;
            move_dir     <= 2'b00;
        end else begin
            if (ps2_data_en && !is_prefix) last_code <= ps2_data;

            if (new_press)    keys_held <= keys_held | key_mask;
            else if (brk_hit) keys_held <= held_after_brk;

            if (new_press) begin
                active_valid <= 1'b1;
                active_dir   <= key_dir;
                cnt          <= DELAY_LD;
            end else if (brk_active) begin
                if (held_after_brk != 4'b0000) begin
                    active_dir <= prio_dir(held_after_brk);
                    cnt        <= DELAY_LD;
                end else begin
                    active_valid <= 1'b0;
                    cnt          <= '0;
                end
            end else if (active_valid) begin
                cnt <= (cnt == '0) ? RATE_LD : cnt - 1'b1;
            end

            // A new press always wins; a repeat only lands if the slot is free this cycle.
            if (new_press) begin
                move_valid <= 1'b1;
                move_dir   <= key_dir;
            end else if (repeat_req && (!move_valid || move_ready)) begin
                move_valid <= 1'b1;
                move_dir   <= active_dir;
            end else if (move_ready) begin
                move_valid <= 1'b0;
            end
        end
    end

endmodule
